// File: rtl/fa_if.sv
// Operand/result bundle for the registered 7-bit adder stage.
// The master drives the operands and reads back the registered sum.
interface fa_if;
  logic [3:0] x;
  logic [6:0] y;
  logic       cin;
  logic [6:0] s;
  logic       cout;

  modport master (output x, output y, output cin, input s, input cout);
  modport slave  (input x, input y, input cin, output s, output cout);
endinterface

// File: rtl/fa.sv
// Registered 7-bit adder stage: s/cout <= y + {3'b000, x} + cin.
// The core is a ripple chain of seven 1-bit full-adder cells.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

module fa (
  input  logic  clk,
  input  logic  rst_n,
  fa_if.slave   bus
);
  logic [6:0] xe;
  logic [7:0] carry;
  logic [6:0] s_next;
  logic       cout_next;
  logic [6:0] s_reg;
  logic       cout_reg;

  assign xe       = {3'b000, bus.x};
  assign carry[0] = bus.cin;

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_cell
      fa_cell u_cell (
        .a     (bus.y[gi]),
        .b     (xe[gi]),
        .c     (carry[gi]),
        .sum   (s_next[gi]),
        .carry (carry[gi+1])
      );
    end
  endgenerate

  assign cout_next = carry[7];

  // The register is what breaks the s -> y feedback loop of the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= 7'd0;
      cout_reg <= 1'b0;
    end else begin
      s_reg    <= s_next;
      cout_reg <= cout_next;
    end
  end

  assign bus.s    = s_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa: directed cases, accumulator feedback,
// async reset, exhaustive sweep and random vectors against y + x + cin.
module tb_fa;
  logic clk;
  logic rst_n;
  fa_if bus ();

  fa dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got cout=%0d s=%0d, expected cout=%0d s=%0d",
               tag, got[7], got[6:0], exp[7], exp[6:0]);
    end
  endtask

  function automatic logic [7:0] model(input int xv, input int yv, input int cv);
    int total;
    total = yv + xv + cv;
    return total[7:0];
  endfunction

  task automatic apply(input string tag, input int xv, input int yv, input int cv);
    @(negedge clk);
    bus.x = xv[3:0]; bus.y = yv[6:0]; bus.cin = cv[0];
    @(posedge clk);
    #1;
    check(tag, {bus.cout, bus.s}, model(xv, yv, cv));
    $display("%s: x=%0d y=%0d cin=%0d -> s=%0d cout=%0d", tag, xv, yv, cv, bus.s, bus.cout);
  endtask

  initial begin
    int acc;
    int xr, yr, cr;
    rst_n = 1'b0;
    bus.x = 4'd0; bus.y = 7'd0; bus.cin = 1'b0;

    // Reset held with random inputs and a running clock.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.x = 4'($urandom); bus.y = 7'($urandom); bus.cin = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", {bus.cout, bus.s}, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    apply("carry_in", 15, 1, 1);
    check("carry_in_val", {bus.cout, bus.s}, 8'd17);
    // New operands must not show before the next edge.
    @(negedge clk);
    bus.x = 4'd13; bus.y = 7'd1; bus.cin = 1'b0;
    #1;
    check("hold_17", {bus.cout, bus.s}, 8'd17);
    @(posedge clk);
    #1;
    check("no_carry_in", {bus.cout, bus.s}, 8'd14);
    apply("wrap", 15, 127, 1);
    check("wrap_val", {bus.cout, bus.s}, 8'd143);
    apply("zero", 0, 0, 0);

    // Sum of N with y tied to s.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("acc_reset", {bus.cout, bus.s}, 8'd0);
    rst_n = 1'b1;
    acc = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.x = 4'(k); bus.y = bus.s; bus.cin = 1'b0;
      acc += k;
      @(posedge clk);
      #1;
      check("sum_of_n", {bus.cout, bus.s}, acc[7:0]);
      $display("sum_of_n: x=%0d -> s=%0d", k, bus.s);
    end

    // Mid-operation reset pulse between edges.
    apply("pre_midrst", 9, 100, 1);
    @(negedge clk);
    bus.x = 4'd6; bus.y = 7'd50; bus.cin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_clear", {bus.cout, bus.s}, 8'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_reload", {bus.cout, bus.s}, model(6, 50, 1));

    // Exhaustive sweep of all x/y/cin combinations.
    for (int v = 0; v < 4096; v++) begin
      @(negedge clk);
      bus.x = v[3:0]; bus.y = v[10:4]; bus.cin = v[11];
      @(posedge clk);
      #1;
      check("exhaustive", {bus.cout, bus.s}, model(v[3:0], v[10:4], v[11]));
    end
    $display("exhaustive: 4096 vectors applied");

    // Random vectors, including occasional async reset pulses.
    for (int i = 0; i < 300; i++) begin
      xr = int'($urandom_range(15, 0));
      yr = int'($urandom_range(127, 0));
      cr = int'($urandom_range(1, 0));
      if ($urandom_range(19, 0) == 0) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rand_rst", {bus.cout, bus.s}, 8'd0);
        rst_n = 1'b1;
      end
      apply("random", xr, yr, cr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
